// File: rtl/apb_transfer_ctrl.sv
// APB master sequencer for the AHB-to-APB bridge.
// Accepts one transfer at a time over a valid/ready request port and decodes
// the address to one of three APB slaves. It then runs the SETUP and ACCESS
// phases and returns a single-cycle response pulse. An address that decodes
// to no slave, or a slave that holds Pready low for too long, produces an
// error response.
module apb_transfer_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Req_valid,
    output logic        Req_ready,
    input  logic        Req_write,
    input  logic [31:0] Req_addr,
    input  logic [31:0] Req_wdata,
    output logic        Rsp_valid,
    output logic        Rsp_err,
    output logic [31:0] Rsp_rdata,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    input  logic [31:0] Prdata,
    input  logic        Pready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // The wait counter can reach TIMEOUT, and TIMEOUT is at most 255, so 8 bits are enough.
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t      r_state;
    logic [7:0]  r_wait;
    logic [2:0]  w_sel;

    // Decode the slave select from the top six address bits. A zero result is a miss.
    always_comb begin
        w_sel = 3'b000;
        case (Req_addr[31:26])
            6'b100000: w_sel = 3'b001;
            6'b100001: w_sel = 3'b010;
            6'b100010: w_sel = 3'b100;
            default:   w_sel = 3'b000;
        endcase
    end

    // The controller accepts a request only in IDLE. The FSM resets to IDLE,
    // so Req_ready is also high during reset.
    assign Req_ready = (r_state == ST_IDLE);

    // Transfer sequencer. The APB output registers also act as the request
    // latches, so the values taken at acceptance stay stable through ACCESS.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Rsp_valid <= 1'b0;
            Rsp_err   <= 1'b0;
            Rsp_rdata <= '0;
        end else begin
            Rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Req_valid) begin
                        if (w_sel != 3'b000) begin
                            r_state <= ST_SETUP;
                            r_wait  <= '0;
                            Pselx   <= w_sel;
                            Penable <= 1'b0;
                            Pwrite  <= Req_write;
                            Paddr   <= Req_addr;
                            Pwdata  <= Req_wdata;
                        end else begin
                            Rsp_valid <= 1'b1;
                            Rsp_err   <= 1'b1;
                            Rsp_rdata <= '0;
                        end
                    end
                end

                ST_SETUP: begin
                    Penable <= 1'b1;
                    r_state <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (Pready) begin
                        Rsp_valid <= 1'b1;
                        Rsp_err   <= 1'b0;
                        Rsp_rdata <= Pwrite ? 32'h0 : Prdata;
                        r_state   <= ST_IDLE;
                        Pselx     <= '0;
                        Penable   <= 1'b0;
                        Pwrite    <= 1'b0;
                        Paddr     <= '0;
                        Pwdata    <= '0;
                    end else if (r_wait == LP_TIMEOUT) begin
                        Rsp_valid <= 1'b1;
                        Rsp_err   <= 1'b1;
                        Rsp_rdata <= '0;
                        r_state   <= ST_IDLE;
                        Pselx     <= '0;
                        Penable   <= 1'b0;
                        Pwrite    <= 1'b0;
                        Paddr     <= '0;
                        Pwdata    <= '0;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    Pselx   <= '0;
                    Penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_transfer_ctrl.sv
// Directed testbench for apb_transfer_ctrl. A table of transfers runs through
// one sequencing task, and separate hand-written sequences cover
// back-to-back requests and reset in the middle of an access.
module tb_apb_transfer_ctrl;

    localparam int unsigned TB_TIMEOUT = 16;

    logic        Hclk;
    logic        Hresetn;
    logic        Req_valid;
    logic        Req_ready;
    logic        Req_write;
    logic [31:0] Req_addr;
    logic [31:0] Req_wdata;
    logic        Rsp_valid;
    logic        Rsp_err;
    logic [31:0] Rsp_rdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;

    int n_cmp = 0;
    int n_err = 0;

    apb_transfer_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Req_valid (Req_valid),
        .Req_ready (Req_ready),
        .Req_write (Req_write),
        .Req_addr  (Req_addr),
        .Req_wdata (Req_wdata),
        .Rsp_valid (Rsp_valid),
        .Rsp_err   (Rsp_err),
        .Rsp_rdata (Rsp_rdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // Hard stop in case a sequence stalls. Every wait below is already bounded.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          n_wait;  // ACCESS cycles with Pready=0 before Pready=1
        logic        hang;    // Pready never rises
        logic [2:0]  sel;     // expected select, 0 = miss
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run one transfer from the table. All sampling happens on the falling edge.
    task automatic run_xfer(input vec_t v);
        @(negedge Hclk);
        Req_valid = 1'b1;
        Req_write = v.write;
        Req_addr  = v.addr;
        Req_wdata = v.wdata;
        Prdata    = v.prdata;
        Pready    = 1'b0;
        chk("req_ready_idle", 32'(Req_ready), 32'd1);
        @(posedge Hclk);            // acceptance edge N
        #1;
        Req_valid = 1'b0;
        Req_addr  = 32'hFFFF_FFFF;  // later changes must not reach the APB side
        Req_wdata = 32'h0BAD_0BAD;
        Req_write = ~v.write;
        if (v.sel != 3'b000) begin
            @(negedge Hclk);        // cycle N+1 : SETUP
            chk("setup_psel",    32'(Pselx),     32'(v.sel));
            chk("setup_penable", 32'(Penable),   32'd0);
            chk("setup_paddr",   Paddr,          v.addr);
            chk("setup_pwdata",  Pwdata,         v.wdata);
            chk("setup_pwrite",  32'(Pwrite),    32'(v.write));
            chk("setup_ready",   32'(Req_ready), 32'd0);
            for (int w = 0; w <= v.n_wait; w++) begin
                @(negedge Hclk);    // cycle N+2+w : ACCESS
                chk("acc_penable", 32'(Penable),   32'd1);
                chk("acc_psel",    32'(Pselx),     32'(v.sel));
                chk("acc_paddr",   Paddr,          v.addr);
                chk("acc_pwdata",  Pwdata,         v.wdata);
                chk("acc_pwrite",  32'(Pwrite),    32'(v.write));
                chk("acc_rspv",    32'(Rsp_valid), 32'd0);
                Pready = (w == v.n_wait) && !v.hang;
            end
            @(negedge Hclk);        // cycle N+3+n_wait : response
            Pready = 1'b0;
        end else begin
            @(negedge Hclk);        // cycle N+1 : miss response
        end
        chk("rsp_valid",   32'(Rsp_valid), 32'd1);
        chk("rsp_err",     32'(Rsp_err),   32'(v.err));
        chk("rsp_rdata",   Rsp_rdata,      v.rdata);
        chk("rsp_psel",    32'(Pselx),     32'd0);
        chk("rsp_penable", 32'(Penable),   32'd0);
        chk("rsp_ready",   32'(Req_ready), 32'd1);
        @(negedge Hclk);            // the pulse ends, err and rdata hold
        chk("pulse_end",  32'(Rsp_valid), 32'd0);
        chk("hold_err",   32'(Rsp_err),   32'(v.err));
        chk("hold_rdata", Rsp_rdata,      v.rdata);
        chk("hold_psel",  32'(Pselx),     32'd0);
    endtask

    initial begin
        //            write  addr           wdata          prdata         wait        hang  sel     err   rdata
        tbl[0] = '{1'b1, 32'h8000_0010, 32'hA5A5_0001, 32'h1111_1111, 0,          1'b0, 3'b001, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h8400_0004, 32'h0,         32'h0000_00C3, 2,          1'b0, 3'b010, 1'b0, 32'h0000_00C3};
        tbl[2] = '{1'b1, 32'h9000_0000, 32'h1234_0000, 32'h0,         0,          1'b0, 3'b000, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 32'h8800_0000, 32'h0,         32'hDEAD_BEEF, TB_TIMEOUT, 1'b1, 3'b100, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 32'h8800_0100, 32'h0,         32'h1234_5678, 0,          1'b0, 3'b100, 1'b0, 32'h1234_5678};
        tbl[5] = '{1'b1, 32'h8400_0008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1,          1'b0, 3'b010, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 32'h7C00_0000, 32'h0,         32'h0,         0,          1'b0, 3'b000, 1'b1, 32'h0};
        tbl[7] = '{1'b0, 32'h83FF_FFFC, 32'h0,         32'h8765_4321, 3,          1'b0, 3'b001, 1'b0, 32'h8765_4321};
        tbl[8] = '{1'b1, 32'h8C00_0000, 32'h5555_AAAA, 32'h0,         0,          1'b0, 3'b000, 1'b1, 32'h0};

        Hresetn   = 1'b0;
        Req_valid = 1'b0;
        Req_write = 1'b0;
        Req_addr  = '0;
        Req_wdata = '0;
        Prdata    = '0;
        Pready    = 1'b0;

        // Reset state
        repeat (2) @(negedge Hclk);
        chk("rst_ready",   32'(Req_ready), 32'd1);
        chk("rst_psel",    32'(Pselx),     32'd0);
        chk("rst_penable", 32'(Penable),   32'd0);
        chk("rst_pwrite",  32'(Pwrite),    32'd0);
        chk("rst_paddr",   Paddr,          32'd0);
        chk("rst_pwdata",  Pwdata,         32'd0);
        chk("rst_rspv",    32'(Rsp_valid), 32'd0);
        chk("rst_rsperr",  32'(Rsp_err),   32'd0);
        chk("rst_rdata",   Rsp_rdata,      32'd0);
        Hresetn = 1'b1;

        for (int i = 0; i < 9; i++) run_xfer(tbl[i]);

        // Back-to-back: the second request is held valid while the first
        // completes, and is accepted in the first request's response cycle.
        @(negedge Hclk);
        Req_valid = 1'b1;
        Req_write = 1'b1;
        Req_addr  = 32'h8000_0020;
        Req_wdata = 32'h0000_BEEF;
        Pready    = 1'b1;
        Prdata    = 32'h0000_0055;
        @(posedge Hclk);            // A accepted at edge N
        #1;
        Req_write = 1'b0;
        Req_addr  = 32'h8400_0030;
        Req_wdata = 32'h0;
        @(negedge Hclk);            // N+1 SETUP A
        chk("b2b_a_setup_psel", 32'(Pselx),     32'd1);
        chk("b2b_a_ready",      32'(Req_ready), 32'd0);
        @(negedge Hclk);            // N+2 ACCESS A
        chk("b2b_a_penable",    32'(Penable),   32'd1);
        @(negedge Hclk);            // N+3 response A, B accepted at the end of this cycle
        chk("b2b_a_rspv",       32'(Rsp_valid), 32'd1);
        chk("b2b_a_err",        32'(Rsp_err),   32'd0);
        chk("b2b_a_rdata",      Rsp_rdata,      32'd0);
        chk("b2b_a_rsp_ready",  32'(Req_ready), 32'd1);
        @(negedge Hclk);            // N+4 SETUP B
        Req_valid = 1'b0;
        chk("b2b_b_setup_psel", 32'(Pselx),     32'd2);
        chk("b2b_b_penable",    32'(Penable),   32'd0);
        chk("b2b_b_paddr",      Paddr,          32'h8400_0030);
        chk("b2b_b_pwrite",     32'(Pwrite),    32'd0);
        chk("b2b_b_rspv",       32'(Rsp_valid), 32'd0);
        @(negedge Hclk);            // N+5 ACCESS B
        chk("b2b_b_acc",        32'(Penable),   32'd1);
        @(negedge Hclk);            // N+6 response B
        chk("b2b_b_rspv",       32'(Rsp_valid), 32'd1);
        chk("b2b_b_rdata",      Rsp_rdata,      32'h0000_0055);
        Pready = 1'b0;

        // Reset in the middle of ACCESS
        @(negedge Hclk);
        Req_valid = 1'b1;
        Req_write = 1'b0;
        Req_addr  = 32'h8000_0040;
        Prdata    = 32'h7777_7777;
        @(posedge Hclk);
        #1;
        Req_valid = 1'b0;
        @(negedge Hclk);            // SETUP
        @(negedge Hclk);            // ACCESS
        chk("mid_penable", 32'(Penable), 32'd1);
        #2;
        Hresetn = 1'b0;
        #1;
        chk("mid_rst_psel",    32'(Pselx),     32'd0);
        chk("mid_rst_penable", 32'(Penable),   32'd0);
        chk("mid_rst_paddr",   Paddr,          32'd0);
        chk("mid_rst_rspv",    32'(Rsp_valid), 32'd0);
        chk("mid_rst_ready",   32'(Req_ready), 32'd1);
        Pready = 1'b1;
        @(negedge Hclk);
        Hresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Hclk);
            chk("post_rst_rspv", 32'(Rsp_valid), 32'd0);
            chk("post_rst_psel", 32'(Pselx),     32'd0);
        end
        Pready = 1'b0;
        run_xfer(tbl[0]);
        run_xfer(tbl[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_transfer_ctrl.md
Name: apb_transfer_ctrl

Overview:
Bridge-side APB master sequencer. It takes single transfer requests from the AHB-side logic (valid/ready), decodes the address to one of three APB slaves, and drives the standard APB SETUP and ACCESS phases. It honours Pready wait states, aborts on a wait-state timeout, and returns read data and an error flag through a one-cycle response pulse. It sits between the AHB slave interface and the APB slave ports (Pselx[2:0], Penable, Pwrite, Paddr, Pwdata, Prdata).

Parameters:
TIMEOUT, 16, maximum consecutive ACCESS cycles with Pready=0 before the transfer is aborted (allowed range 1..255).

Ports:
Hclk  input  1  clock; all logic is rising-edge.
Hresetn  input  1  asynchronous active-low reset.
Req_valid  input  1  request present.
Req_ready  output  1  controller can accept a request; high only in IDLE.
Req_write  input  1  1 = write, 0 = read.
Req_addr  input  32  transfer address.
Req_wdata  input  32  write data.
Rsp_valid  output  1  one-cycle completion pulse.
Rsp_err  output  1  error qualifier; valid only while Rsp_valid=1.
Rsp_rdata  output  32  read data; valid while Rsp_valid=1 and the transfer was a read.
Pselx  output  3  one-hot APB slave select.
Penable  output  1  APB access phase.
Pwrite  output  1  APB direction.
Paddr  output  32  APB address.
Pwdata  output  32  APB write data.
Prdata  input  32  APB read data.
Pready  input  1  APB slave ready.

Behaviour:
- One clock (Hclk), asynchronous active-low reset (Hresetn).
- Reset values: state=IDLE; Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Rsp_valid=0, Rsp_err=0, Rsp_rdata=0, wait counter=0. Req_ready=1 while in reset.
- Reset mid-transfer: the transfer is dropped, no response is issued, and the APB outputs clear immediately.
- Address decode on Req_addr[31:26]:
  - 6'b100000 -> Pselx=3'b001
  - 6'b100001 -> Pselx=3'b010
  - 6'b100010 -> Pselx=3'b100
  - any other value is a miss.
- Accept rule: a request is accepted at the edge where Req_valid & Req_ready. On acceptance, addr, wdata, write and the decoded select are latched. Inputs are ignored at all other times.
- State IDLE:
  - Req_ready=1; all APB outputs are 0.
  - Accepted hit -> SETUP.
  - Accepted miss -> stay in IDLE; Rsp_valid=1 and Rsp_err=1 with Rsp_rdata=0 in the next cycle. No APB activity occurs.
- State SETUP (exactly one cycle):
  - Pselx=latched select, Penable=0.
  - Paddr, Pwdata and Pwrite are driven from the latches.
  - Next state is ACCESS.
- State ACCESS:
  - Penable=1; Pselx, Paddr, Pwdata and Pwrite are held stable.
  - If Pready=1 at the edge:
    - a read captures Prdata into Rsp_rdata;
    - a write sets Rsp_rdata=0;
    - Rsp_err=0, Rsp_valid=1 in the next cycle;
    - next state is IDLE and the APB outputs return to 0.
  - If Pready=0, the wait counter increments. When the counter equals TIMEOUT at an edge with Pready still 0:
    - the transfer aborts and the next state is IDLE;
    - next cycle: Rsp_valid=1, Rsp_err=1, Rsp_rdata=0.
  - The wait counter clears on every entry to SETUP.
- Latency, measured from acceptance edge N:
  - Cycle N+1 is SETUP.
  - Cycle N+2 is ACCESS.
  - With zero wait states, Rsp_valid is high in cycle N+3.
  - Each wait state adds one cycle.
  - Peak throughput is one transfer per 3 cycles.
- Rsp_valid is a pulse and deasserts after exactly one cycle.
- A new request can be accepted in the same cycle Rsp_valid is high, because the controller is back in IDLE.
- Rsp_err and Rsp_rdata hold their values until the next response.
- Pselx is never non-zero outside SETUP/ACCESS. Penable is never 1 outside ACCESS.

Test Plan:
- Write hit, Pready tied 1: Req addr=0x8000_0010, wdata=0xA5A5_0001, write=1 -> SETUP with Pselx=001, Penable=0, Paddr=0x8000_0010; ACCESS with Penable=1; Rsp_valid high exactly 3 cycles after acceptance, Rsp_err=0.
- Read with wait states: addr=0x8400_0004, Pready=0 for 2 ACCESS cycles then 1 with Prdata=0x0000_00C3 -> Pselx=010 and signals stable throughout; Rsp_rdata=0x0000_00C3, Rsp_valid 5 cycles after acceptance.
- Decode miss: addr=0x9000_0000 -> no Pselx/Penable activity; Rsp_valid=1, Rsp_err=1 the next cycle; Req_ready stays 1.
- Timeout (TIMEOUT=16): addr=0x8800_0000, Pready held 0 -> abort after 16 wait cycles; Rsp_err=1, Rsp_rdata=0; Pselx=0 the next cycle.
- Back-to-back: a second request is held valid while the first completes -> accepted in the Rsp_valid cycle; the second SETUP begins the following cycle.
- Reset mid-ACCESS: Hresetn=0 asynchronously -> all outputs 0 immediately; no Rsp_valid after release; the next request completes normally.
